// File: rtl/qmac_pipe_if.sv
// Valid/ready bus of the pipelined fixed-point MAC: input beats in, requantised sums out.
// The slave modport is the MAC itself and the master modport is its environment.
interface qmac_pipe_if #(
  parameter int ACT_W = 16,
  parameter int WGT_W = 16,
  parameter int ACC_W = 40,
  parameter int OUT_W = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [ACT_W-1:0] i_act;
  logic [WGT_W-1:0] i_wgt;
  logic             i_first;
  logic             i_last;
  logic             o_valid;
  logic             i_ready;
  logic [OUT_W-1:0] o_data;
  logic [ACC_W-1:0] o_acc;
  logic             o_sat;

  modport slave (
    input  i_valid, i_act, i_wgt, i_first, i_last, i_ready,
    output o_ready, o_valid, o_data, o_acc, o_sat
  );

  modport master (
    output i_valid, i_act, i_wgt, i_first, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_acc, o_sat
  );
endinterface

// File: rtl/qmac_pipe.sv
// Pipelined signed multiply-accumulate with framed sums, round-half-up requantisation
// and saturation. The whole pipeline advances together when the output slot can move.
module qmac_pipe #(
  parameter int ACT_W    = 16,
  parameter int ACT_FRAC = 12,
  parameter int WGT_W    = 16,
  parameter int WGT_FRAC = 14,
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  qmac_pipe_if.slave   bus
);
  localparam int PROD_W = ACT_W + WGT_W;
  localparam int SHIFT  = ACT_FRAC + WGT_FRAC - OUT_FRAC;
  localparam logic [ACC_W:0] RND_HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

  // Returns {clip flag, clamped value}. In-range means all bits from the output sign upward agree.
  function automatic logic [OUT_W:0] sat_fn(input logic [ACC_W:0] x);
    logic [ACC_W-OUT_W+1:0] hi;
    hi = x[ACC_W:OUT_W-1];
    if ((&hi) || (~|hi)) begin
      sat_fn = {1'b0, x[OUT_W-1:0]};
    end else if (x[ACC_W]) begin
      sat_fn = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat_fn = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

  logic                     w_adv;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_p_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic        [ACC_W:0]    w_rnd_sum;
  logic signed [ACC_W:0]    w_shifted;
  logic        [OUT_W:0]    w_q;

  logic signed [PROD_W-1:0] r_p;
  logic                     r_p_v;
  logic                     r_p_first;
  logic                     r_p_last;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_o_valid;
  logic        [OUT_W-1:0]  r_o_data;
  logic        [ACC_W-1:0]  r_o_acc;
  logic                     r_o_sat;

  assign w_adv       = ~r_o_valid | bus.i_ready;
  assign bus.o_ready = w_adv;

  assign w_prod    = PROD_W'($signed(bus.i_act)) * PROD_W'($signed(bus.i_wgt));
  assign w_p_ext   = ACC_W'(r_p);
  assign w_sum     = r_p_first ? w_p_ext : (r_acc + w_p_ext);
  // One extra bit so adding the half-LSB can never wrap.
  assign w_rnd_sum = {w_sum[ACC_W-1], w_sum} + RND_HALF;
  assign w_shifted = $signed(w_rnd_sum) >>> SHIFT;
  assign w_q       = sat_fn(w_shifted);

  // Product stage: registered product and frame markers of the accepted beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p       <= '0;
      r_p_v     <= 1'b0;
      r_p_first <= 1'b0;
      r_p_last  <= 1'b0;
    end else if (w_adv) begin
      r_p       <= w_prod;
      r_p_v     <= bus.i_valid;
      r_p_first <= bus.i_first;
      r_p_last  <= bus.i_last;
    end
  end

  // Accumulator: only real products update it, so bubbles leave the running sum untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (w_adv && r_p_v) begin
      r_acc <= w_sum;
    end
  end

  // Output slot: loads on a frame's last product, drains when downstream takes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
      r_o_acc   <= '0;
      r_o_sat   <= 1'b0;
    end else if (w_adv) begin
      if (r_p_v && r_p_last) begin
        r_o_valid <= 1'b1;
        r_o_acc   <= w_sum;
        r_o_data  <= w_q[OUT_W-1:0];
        r_o_sat   <= w_q[OUT_W];
      end else if (bus.i_ready) begin
        r_o_valid <= 1'b0;
      end
    end
  end

  assign bus.o_valid = r_o_valid;
  assign bus.o_data  = r_o_data;
  assign bus.o_acc   = r_o_acc;
  assign bus.o_sat   = r_o_sat;
endmodule

// File: tb/tb_qmac_pipe.sv
// Directed bench for qmac_pipe: framing, rounding, saturation, backpressure and mid-frame reset.
module tb_qmac_pipe;
  logic i_clk;
  logic i_rst_n;
  int   vectors;
  int   miscompares;

  qmac_pipe_if #(.ACT_W(16), .WGT_W(16), .ACC_W(40), .OUT_W(16)) bus ();

  qmac_pipe dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] data,
                            input logic [39:0] acc, input logic sat);
    check({tag, ".valid"}, 64'(bus.o_valid), 64'd1);
    check({tag, ".data"},  64'(bus.o_data),  64'(data));
    check({tag, ".acc"},   64'(bus.o_acc),   64'(acc));
    check({tag, ".sat"},   64'(bus.o_sat),   64'(sat));
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] act, input logic [15:0] wgt,
                      input logic first, input logic last);
    bus.i_valid = 1'b1;
    bus.i_act   = act;
    bus.i_wgt   = wgt;
    bus.i_first = first;
    bus.i_last  = last;
    tick();
    bus.i_valid = 1'b0;
    bus.i_first = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_rst_n     = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_act   = 16'h0000;
    bus.i_wgt   = 16'h0000;
    bus.i_first = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b1;
    #12;
    check("rst.valid", 64'(bus.o_valid), 64'd0);
    check("rst.ready", 64'(bus.o_ready), 64'd1);
    check("rst.data",  64'(bus.o_data),  64'd0);
    check("rst.acc",   64'(bus.o_acc),   64'd0);
    check("rst.sat",   64'(bus.o_sat),   64'd0);
    i_rst_n = 1'b1;
    tick();

    // Single-product frame: 1.5 * 0.5 = 0.75
    beat(16'h1800, 16'h2000, 1'b1, 1'b1);
    check("single.lat", 64'(bus.o_valid), 64'd0);
    tick();
    expect_out("single", 16'h0C00, 40'h0003000000, 1'b0);

    // Four-beat frame followed immediately by the next frame
    beat(16'h1800, 16'h2000, 1'b1, 1'b0);
    check("frame4.b1", 64'(bus.o_valid), 64'd0);
    beat(16'h1800, 16'h2000, 1'b0, 1'b0);
    beat(16'h1800, 16'h2000, 1'b0, 1'b0);
    check("frame4.b3", 64'(bus.o_valid), 64'd0);
    beat(16'h1800, 16'h2000, 1'b0, 1'b1);
    check("frame4.b4", 64'(bus.o_valid), 64'd0);
    beat(16'h0001, 16'h2000, 1'b1, 1'b1);
    expect_out("frame4", 16'h3000, 40'h000C000000, 1'b0);
    tick();
    expect_out("rnd_up", 16'h0001, 40'h0000002000, 1'b0);

    // Rounding toward +inf on exact halves and below
    beat(16'hFFFF, 16'h2000, 1'b1, 1'b1);
    beat(16'hFFFF, 16'h6000, 1'b1, 1'b1);
    expect_out("rnd_half_neg", 16'h0000, 40'hFFFFFFE000, 1'b0);
    tick();
    expect_out("rnd_neg", 16'hFFFF, 40'hFFFFFFA000, 1'b0);

    // Saturation both directions
    beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    beat(16'h8000, 16'h7FFF, 1'b1, 1'b1);
    expect_out("sat_pos", 16'h7FFF, 40'h003FFF0001, 1'b1);
    tick();
    expect_out("sat_neg", 16'h8000, 40'hFFC0008000, 1'b1);
    tick();
    check("drain.valid", 64'(bus.o_valid), 64'd0);

    // Backpressure: X reaches the output, Y sits in the product stage, Z waits upstream
    beat(16'h1800, 16'h2000, 1'b1, 1'b1);
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_act   = 16'h0001;
    bus.i_wgt   = 16'h2000;
    bus.i_first = 1'b1;
    bus.i_last  = 1'b1;
    tick();
    expect_out("bp.x", 16'h0C00, 40'h0003000000, 1'b0);
    bus.i_act = 16'hFFFF;
    bus.i_wgt = 16'h6000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.ready", 64'(bus.o_ready), 64'd0);
      check("bp.hold",  64'(bus.o_data),  64'h0C00);
      check("bp.valid", 64'(bus.o_valid), 64'd1);
    end
    bus.i_ready = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    bus.i_first = 1'b0;
    bus.i_last  = 1'b0;
    expect_out("bp.y", 16'h0001, 40'h0000002000, 1'b0);
    tick();
    expect_out("bp.z", 16'hFFFF, 40'hFFFFFFA000, 1'b0);
    tick();
    check("bp.done", 64'(bus.o_valid), 64'd0);

    // Reset after two beats of a frame discards the partial sum
    beat(16'h1800, 16'h2000, 1'b1, 1'b0);
    beat(16'h1800, 16'h2000, 1'b0, 1'b0);
    bus.i_ready = 1'b0;
    i_rst_n = 1'b0;
    #2;
    check("mrst.valid", 64'(bus.o_valid), 64'd0);
    check("mrst.ready", 64'(bus.o_ready), 64'd1);
    check("mrst.data",  64'(bus.o_data),  64'd0);
    check("mrst.acc",   64'(bus.o_acc),   64'd0);
    check("mrst.sat",   64'(bus.o_sat),   64'd0);
    i_rst_n = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    beat(16'h0001, 16'h2000, 1'b0, 1'b0);
    beat(16'h0001, 16'h2000, 1'b0, 1'b1);
    tick();
    expect_out("post_rst", 16'h0001, 40'h0000004000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
